// File: rtl/uart_prog_loader.sv
// Host-side program-load engine: parses '#'-framed UART packets, writes/reads program memory, sends framed replies.
// Define LOADER_TIMEOUT_EN to abort a stalled packet after TIMEOUT_CYCLES idle cycles.
module uart_prog_loader #(
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        progmem_wen,
   output logic [31:0] progmem_waddr,
   output logic [31:0] progmem_wdata,
   output logic [31:0] progmem_raddr,
   input  logic [31:0] progmem_rdata,
   output logic        soc_hold,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_LEN_H, S_LEN_L, S_ADDR, S_DATA, S_CKS, S_EOP,
      S_RESP, S_RADDR, S_RLATCH
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  cmd, sum, rsum, status, resp_byte;
   logic [15:0] len, cnt;
   logic [31:0] addr, word, rword;
   logic [16:0] ridx, n_data;
   logic        eop_bad, cks_bad, have_word;
   logic        bad, has_data, data_phase, need_fetch, resp_done, can_send, timeout;

   assign busy       = (state != S_IDLE);
   assign bad        = !(cmd == 8'h07 || cmd == 8'h08) || (len[1:0] != 2'b00);
   assign status     = bad ? 8'h02 : (eop_bad ? 8'h03 : (cks_bad ? 8'h01 : 8'h00));
   assign has_data   = (cmd != 8'h08) && (len != 16'd0);
   assign n_data     = (cmd == 8'h08 && status == 8'h00) ? {1'b0, len} : 17'd0;
   assign data_phase = (ridx >= 17'd3) && (ridx < 17'd3 + n_data);
   // Response byte index 3 is the first data byte, so word boundaries sit at ridx[1:0]==3.
   assign need_fetch = data_phase && (ridx[1:0] == 2'd3) && !have_word;
   assign resp_done  = (ridx == n_data + 17'd5);
   assign can_send   = !tx_busy && !tx_start && !need_fetch && !resp_done;

   always_comb begin
      resp_byte = 8'h0D;
      if (ridx == 17'd0)                resp_byte = 8'h23;
      else if (ridx == 17'd1)           resp_byte = cmd;
      else if (ridx == 17'd2)           resp_byte = status;
      else if (data_phase)              resp_byte = rword[7:0];
      else if (ridx == 17'd3 + n_data)  resp_byte = rsum;
   end

`ifdef LOADER_TIMEOUT_EN
   logic [31:0] tcnt;
   logic        in_parse;
   assign in_parse = (state != S_IDLE) && (state != S_RESP) &&
                     (state != S_RADDR) && (state != S_RLATCH);
   always_ff @(posedge clk) begin
      if (!resetn || rx_valid || !in_parse) tcnt <= '0;
      else                                  tcnt <= tcnt + 32'd1;
   end
   assign timeout = in_parse && !rx_valid && (tcnt == 32'(TIMEOUT_CYCLES));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (rx_valid && rx_data == 8'h23) state_nx = S_CMD;
         S_CMD:    if (rx_valid) state_nx = S_LEN_H;
         S_LEN_H:  if (rx_valid) state_nx = S_LEN_L;
         S_LEN_L:  if (rx_valid) state_nx = S_ADDR;
         S_ADDR:   if (rx_valid && cnt == 16'd3) state_nx = has_data ? S_DATA : S_CKS;
         S_DATA:   if (rx_valid && cnt == len - 16'd1) state_nx = S_CKS;
         S_CKS:    if (rx_valid) state_nx = S_EOP;
         S_EOP:    if (rx_valid) state_nx = S_RESP;
         S_RESP:   if (need_fetch) state_nx = S_RADDR;
                   else if (resp_done) state_nx = S_IDLE;
         S_RADDR:  state_nx = S_RLATCH;
         S_RLATCH: state_nx = S_RESP;
         default:  state_nx = S_IDLE;
      endcase
      if (timeout) state_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cmd <= '0; sum <= '0; rsum <= '0; len <= '0; cnt <= '0;
         addr <= '0; word <= '0; rword <= '0; ridx <= '0;
         eop_bad <= 1'b0; cks_bad <= 1'b0; have_word <= 1'b0;
         tx_data <= '0; tx_start <= 1'b0; progmem_wen <= 1'b0;
         progmem_waddr <= '0; progmem_wdata <= '0; progmem_raddr <= '0;
         soc_hold <= 1'b0;
      end else begin
         progmem_wen <= 1'b0;
         tx_start    <= 1'b0;
         case (state)
            S_IDLE: if (rx_valid && rx_data == 8'h23) begin
               eop_bad <= 1'b0;
               cks_bad <= 1'b0;
            end
            S_CMD: if (rx_valid) begin
               cmd      <= rx_data;
               sum      <= rx_data;
               soc_hold <= (rx_data == 8'h07);
            end
            S_LEN_H: if (rx_valid) begin
               len[15:8] <= rx_data;
               sum       <= sum + rx_data;
            end
            S_LEN_L: if (rx_valid) begin
               len[7:0] <= rx_data;
               sum      <= sum + rx_data;
               cnt      <= '0;
            end
            S_ADDR: if (rx_valid) begin
               addr <= {addr[23:0], rx_data};
               sum  <= sum + rx_data;
               cnt  <= (cnt == 16'd3) ? 16'd0 : cnt + 16'd1;
            end
            S_DATA: if (rx_valid) begin
               word <= {rx_data, word[31:8]};
               sum  <= sum + rx_data;
               cnt  <= cnt + 16'd1;
               // Commit each completed word immediately; a bad checksum later cannot undo it.
               if (cnt[1:0] == 2'd3 && !bad) begin
                  progmem_wen   <= 1'b1;
                  progmem_waddr <= {2'b00, addr[31:2]};
                  progmem_wdata <= {rx_data, word[31:8]};
                  addr          <= addr + 32'd4;
               end
            end
            S_CKS: if (rx_valid) cks_bad <= (rx_data != sum);
            S_EOP: if (rx_valid) begin
               eop_bad   <= (rx_data != 8'h0D);
               soc_hold  <= 1'b0;
               ridx      <= '0;
               rsum      <= '0;
               have_word <= 1'b0;
            end
            S_RESP: begin
               if (need_fetch) begin
                  progmem_raddr <= {2'b00, addr[31:2]};
               end else if (can_send) begin
                  tx_start <= 1'b1;
                  tx_data  <= resp_byte;
                  ridx     <= ridx + 17'd1;
                  if (ridx != 17'd0 && ridx < 17'd3 + n_data) rsum <= rsum + resp_byte;
                  if (data_phase) begin
                     rword <= {8'h00, rword[31:8]};
                     if (ridx[1:0] == 2'd2) have_word <= 1'b0;
                  end
               end
            end
            S_RLATCH: begin
               rword     <= progmem_rdata;
               have_word <= 1'b1;
               addr      <= addr + 32'd4;
            end
            default: ;
         endcase
         if (timeout) soc_hold <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: packet stimulus with hand-computed checksums and replies.
module tb_uart_prog_loader;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        progmem_wen;
   logic [31:0] progmem_waddr, progmem_wdata, progmem_raddr, progmem_rdata;
   logic        soc_hold, busy;

   int          n_cmp = 0;
   int          n_err = 0;
   int          tx_viol = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_tx[$];
   logic [63:0] exp_wr_q[$];
   logic [63:0] got_wr[$];
   logic [31:0] mem [0:15];
   logic [3:0]  tx_cnt = '0;
   logic        prev_start = 1'b0;

   always #5 clk = ~clk;

   uart_prog_loader #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .progmem_wen(progmem_wen), .progmem_waddr(progmem_waddr), .progmem_wdata(progmem_wdata),
      .progmem_raddr(progmem_raddr), .progmem_rdata(progmem_rdata),
      .soc_hold(soc_hold), .busy(busy)
   );

   // Transmitter model: busy for 4 cycles starting the cycle after tx_start; memory with 1-cycle read.
   assign tx_busy = (tx_cnt != 4'd0);
   always @(posedge clk) begin
      if (tx_start)            tx_cnt <= 4'd4;
      else if (tx_cnt != 4'd0) tx_cnt <= tx_cnt - 4'd1;
      progmem_rdata <= mem[progmem_raddr[3:0]];
   end

   always @(negedge clk) begin
      if (tx_start) got_tx.push_back(tx_data);
      if (tx_start && (tx_busy || prev_start)) tx_viol++;
      prev_start = tx_start;
      if (progmem_wen) got_wr.push_back({progmem_waddr, progmem_wdata});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [255:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
   endtask

   task automatic expect_tx(input logic [255:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      exp_wr_q.push_back({a, d});
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_idle"}, busy, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_tx(input string tag);
      check({tag, "_txn"}, got_tx.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_tx.size()) check($sformatf("%s_tx%0d", tag, i), got_tx[i], exp_q[i]);
      check({tag, "_txrule"}, tx_viol, 0);
      got_tx.delete();
      exp_q.delete();
   endtask

   task automatic check_wr(input string tag);
      check({tag, "_wrn"}, got_wr.size(), exp_wr_q.size());
      for (int i = 0; i < exp_wr_q.size(); i++)
         if (i < got_wr.size()) check($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr_q[i]);
      got_wr.delete();
      exp_wr_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[4] = 32'h11223344;
      repeat (3) @(negedge clk);
      check("rst_ctl", {busy, soc_hold, tx_start, progmem_wen}, 4'b0);
      check("rst_txd", tx_data, 8'h00);
      check("rst_waddr", progmem_waddr, 32'h0);
      check("rst_wdata", progmem_wdata, 32'h0);
      check("rst_raddr", progmem_raddr, 32'h0);
      resetn = 1'b1;
      @(negedge clk);

      // Noise, then single-word write with hold/latency checks.
      send_byte(8'h55);
      send_byte(8'hAA);
      check("noise_idle", busy, 1'b0);
      send_byte(8'h23);
      send_byte(8'h07);
      check("t1_hold_cmd", soc_hold, 1'b1);
      send_vec(72'h00_04_00_00_00_10_EF_BE_AD, 9);
      check("t1_nowen_early", progmem_wen, 1'b0);
      send_byte(8'hDE);
      check("t1_wen", progmem_wen, 1'b1);
      check("t1_waddr", progmem_waddr, 32'h4);
      check("t1_wdata", progmem_wdata, 32'hDEADBEEF);
      send_byte(8'h53);
      check("t1_hold_cks", soc_hold, 1'b1);
      send_byte(8'h0D);
      check("t1_hold_resp", soc_hold, 1'b0);
      check("t1_busy_resp", busy, 1'b1);
      check("t1_no_early_tx", tx_start, 1'b0);
      wait_idle("t1");
      expect_tx(40'h23_07_00_07_0D, 5);
      check_tx("t1");
      expect_wr(32'h4, 32'hDEADBEEF);
      check_wr("t1");

      // Two words with a checksum one too high: both committed, status 01.
      send_vec(144'h23_07_00_08_00_00_00_20_01_02_03_04_05_06_07_08_54_0D, 18);
      wait_idle("t2");
      expect_tx(40'h23_07_01_08_0D, 5);
      check_tx("t2");
      expect_wr(32'h8, 32'h04030201);
      expect_wr(32'h9, 32'h08070605);
      check_wr("t2");

      // Read-back of mem[4].
      send_vec(80'h23_08_00_04_00_00_00_10_1C_0D, 10);
      wait_idle("t3");
      expect_tx(72'h23_08_00_44_33_22_11_B2_0D, 9);
      check_tx("t3");
      check("t3_raddr", progmem_raddr, 32'h4);
      check_wr("t3");

      // LEN=3 write: three data bytes consumed, nothing written.
      send_vec(104'h23_07_00_03_00_00_00_00_AA_BB_CC_3B_0D, 13);
      wait_idle("t4a");
      expect_tx(40'h23_07_02_09_0D, 5);
      check_tx("t4a");
      check_wr("t4a");

      // Bad EOP byte: word written, status 03.
      send_vec(112'h23_07_00_04_00_00_00_00_11_22_33_44_B5_0A, 14);
      wait_idle("t4b");
      expect_tx(40'h23_07_03_0A_0D, 5);
      check_tx("t4b");
      expect_wr(32'h0, 32'h44332211);
      check_wr("t4b");

      // Unknown command.
      send_vec(80'h23_09_00_00_00_00_00_00_09_0D, 10);
      wait_idle("t4c");
      expect_tx(40'h23_09_02_0B_0D, 5);
      check_tx("t4c");
      check_wr("t4c");

      // Word index wraps from 2^30-1 to 0.
      send_vec(144'h23_07_00_08_FF_FF_FF_FC_01_00_00_00_02_00_00_00_0B_0D, 18);
      wait_idle("twrap");
      expect_tx(40'h23_07_00_07_0D, 5);
      check_tx("twrap");
      expect_wr(32'h3FFFFFFF, 32'h00000001);
      expect_wr(32'h00000000, 32'h00000002);
      check_wr("twrap");

      // Reset after the 2nd data byte, then a clean packet.
      send_vec(80'h23_07_00_08_00_00_00_30_01_02, 10);
      check("t5_hold_pre", soc_hold, 1'b1);
      resetn = 1'b0;
      @(negedge clk);
      check("t5_rst_ctl", {busy, soc_hold, tx_start, progmem_wen}, 4'b0);
      check("t5_rst_txd", tx_data, 8'h00);
      check("t5_rst_wdata", progmem_wdata, 32'h0);
      check("t5_rst_raddr", progmem_raddr, 32'h0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check_wr("t5_rst");
      check_tx("t5_rst");
      send_vec(112'h23_07_00_04_00_00_00_10_EF_BE_AD_DE_53_0D, 14);
      wait_idle("t5");
      expect_tx(40'h23_07_00_07_0D, 5);
      check_tx("t5");
      expect_wr(32'h4, 32'hDEADBEEF);
      check_wr("t5");

`ifdef LOADER_TIMEOUT_EN
      // Stall after LEN_L: the packet is abandoned silently.
      send_vec(32'h23_07_00_04, 4);
      repeat (50) @(negedge clk);
      check("t6_busy_mid", busy, 1'b1);
      check("t6_hold_mid", soc_hold, 1'b1);
      repeat (60) @(negedge clk);
      check("t6_busy_end", busy, 1'b0);
      check("t6_hold_end", soc_hold, 1'b0);
      check_tx("t6_silent");
      send_vec(112'h23_07_00_04_00_00_00_10_EF_BE_AD_DE_53_0D, 14);
      wait_idle("t6");
      expect_tx(40'h23_07_00_07_0D, 5);
      check_tx("t6");
      expect_wr(32'h4, 32'hDEADBEEF);
      check_wr("t6");
`else
      // Without the timeout a stalled packet waits indefinitely.
      send_vec(32'h23_08_00_00, 4);
      repeat (150) @(negedge clk);
      check("t6_busy_stall", busy, 1'b1);
      send_vec(48'h00_00_00_00_08_0D, 6);
      wait_idle("t6");
      expect_tx(40'h23_08_00_08_0D, 5);
      check_tx("t6");
      check_wr("t6");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
